// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types and widths for the two-master bus arbiter.
//                The request bundle, FSM state enum and a small helper that
//                maps a master index onto its ownership state.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_ADDR_W = 24;
    localparam int BUS_DATA_W = 16;

    // One master's request, bundled so the top can mux it as a unit.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic                  re;
        logic                  we;
        logic [BUS_DATA_W-1:0] wdata;
        logic                  lock;
    } bus_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Ownership state for master index idx (0 -> OWN0, 1 -> OWN1).
    function automatic arb_state_e own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational tie-break for two requesters. Returns a
//                one-hot winner. A lone requester always wins. On a tie the
//                macro BUS_ARB_ROUND_ROBIN_EN selects round-robin (the master
//                that did not win last time), otherwise master 0 wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Tie goes to the master that did not win the previous completion.
    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            win_o = last_i ? 2'b01 : 2'b10;
        end
    end
`else
    // Previous winner is irrelevant with fixed priority.
    logic w_unused_last;
    assign w_unused_last = last_i;

    // Tie always goes to master 0.
    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            win_o = 2'b01;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master arbiter for the 24-bit external memory bus.
//                Master 0 is the CPU memory controller, master 1 a DMA or
//                debug requester. Handles slave wait stretching, locked
//                back-to-back sequences (bounded by LOCK_MAX completions) and
//                per-master wait signalling. Tie-break policy is selected by
//                the macro BUS_ARB_ROUND_ROBIN_EN (undefined: fixed priority,
//                master 0 wins ties).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] m0_addr_i,
    input  logic                  m0_re_i,
    input  logic                  m0_we_i,
    input  logic [BUS_DATA_W-1:0] m0_wdata_i,
    input  logic                  m0_lock_i,
    input  logic [BUS_ADDR_W-1:0] m1_addr_i,
    input  logic                  m1_re_i,
    input  logic                  m1_we_i,
    input  logic [BUS_DATA_W-1:0] m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic [BUS_DATA_W-1:0] m0_rdata_o,
    output logic [BUS_DATA_W-1:0] m1_rdata_o,
    output logic                  m0_wait_o,
    output logic                  m1_wait_o,
    output logic [BUS_ADDR_W-1:0] bus_addr_o,
    output logic                  bus_re_o,
    output logic                  bus_we_o,
    output logic [BUS_DATA_W-1:0] bus_data_o,
    output logic                  bus_data_oe_o,
    input  logic [BUS_DATA_W-1:0] bus_data_i,
    input  logic                  bus_wait_i,
    output logic [1:0]            grant_o
);

    localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

    bus_req_t   w_m0_req;
    bus_req_t   w_m1_req;
    bus_req_t   w_drv;
    logic [1:0] w_req;
    logic [1:0] w_win;
    logic [1:0] w_sel;
    logic       w_idx;
    logic       w_comp;

    arb_state_e state_q;
    logic       last_q;
    logic [7:0] lock_cnt_q;
    logic [7:0] lock_cnt_d;
    logic [1:0] grant_q;

    assign w_m0_req = '{addr: m0_addr_i, re: m0_re_i, we: m0_we_i,
                        wdata: m0_wdata_i, lock: m0_lock_i};
    assign w_m1_req = '{addr: m1_addr_i, re: m1_re_i, we: m1_we_i,
                        wdata: m1_wdata_i, lock: m1_lock_i};

    assign w_req = {m1_re_i | m1_we_i, m0_re_i | m0_we_i};

    arb_pick u_arb_pick (
        .req_i  (w_req),
        .last_i (last_q),
        .win_o  (w_win)
    );

    // Which master is on the bus this cycle; nothing is driven during reset
    // so the strobes fall as soon as rst rises.
    always_comb begin
        w_sel = 2'b00;
        if (!rst) begin
            case (state_q)
                IDLE:    w_sel = w_win;
                OWN0:    w_sel = {1'b0, w_req[0]};
                OWN1:    w_sel = {w_req[1], 1'b0};
                default: w_sel = 2'b00;
            endcase
        end
    end

    assign w_idx  = w_sel[1];
    assign w_comp = (|w_sel) & ~bus_wait_i;

    // Mux the selected master's request onto the shared bus (zero if none).
    always_comb begin
        w_drv = '0;
        if (w_sel[0]) begin
            w_drv = w_m0_req;
        end else if (w_sel[1]) begin
            w_drv = w_m1_req;
        end
    end

    // Counter value after one more completion, saturating at LOCK_MAX.
    assign lock_cnt_d = (lock_cnt_q >= c_lock_max) ? lock_cnt_q : lock_cnt_q + 8'd1;

    // Ownership FSM; lock_cnt_q counts completions of the current ownership,
    // including the one that opened it from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= 8'd0;
            grant_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|w_sel) begin
                        if (bus_wait_i) begin
                            state_q    <= own_state(w_idx);
                            grant_q    <= w_sel;
                            lock_cnt_q <= 8'd0;
                        end else begin
                            last_q <= w_idx;
                            if (w_drv.lock && (8'd1 < c_lock_max)) begin
                                state_q    <= own_state(w_idx);
                                grant_q    <= w_sel;
                                lock_cnt_q <= 8'd1;
                            end
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (!(|w_sel)) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'b00;
                        lock_cnt_q <= 8'd0;
                    end else if (w_comp) begin
                        last_q <= w_idx;
                        if (!w_drv.lock || (lock_cnt_d >= c_lock_max)) begin
                            state_q    <= IDLE;
                            grant_q    <= 2'b00;
                            lock_cnt_q <= 8'd0;
                        end else begin
                            lock_cnt_q <= lock_cnt_d;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= 2'b00;
                    lock_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign bus_addr_o    = w_drv.addr;
    assign bus_re_o      = w_drv.re;
    assign bus_we_o      = w_drv.we;
    assign bus_data_o    = w_drv.wdata;
    assign bus_data_oe_o = w_drv.we;

    assign m0_rdata_o = bus_data_i;
    assign m1_rdata_o = bus_data_i;

    assign m0_wait_o = w_req[0] & ~(w_sel[0] & ~bus_wait_i);
    assign m1_wait_o = w_req[1] & ~(w_sel[1] & ~bus_wait_i);

    assign grant_o = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. A behavioural model
//                (owner / last winner / held-count) predicts every output
//                each cycle; directed sequences pin the model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int TB_LM = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_re_i = 1'b0, m0_we_i = 1'b0, m0_lock_i = 1'b0;
    logic        m1_re_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
    logic [15:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [15:0] bus_data_i = '0;
    logic        bus_wait_i = 1'b0;
    logic [15:0] m0_rdata_o, m1_rdata_o, bus_data_o;
    logic        m0_wait_o, m1_wait_o, bus_re_o, bus_we_o, bus_data_oe_o;
    logic [23:0] bus_addr_o;
    logic [1:0]  grant_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index (-1 = none), last winner, completions held.
    int m_own  = -1;
    int m_last = 1;
    int m_held = 0;

    bus_arbiter #(.LOCK_MAX(TB_LM)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_re_i(m0_re_i), .m0_we_i(m0_we_i),
        .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i),
        .m1_addr_i(m1_addr_i), .m1_re_i(m1_re_i), .m1_we_i(m1_we_i),
        .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .m0_wait_o(m0_wait_o), .m1_wait_o(m1_wait_o),
        .bus_addr_o(bus_addr_o), .bus_re_o(bus_re_o), .bus_we_o(bus_we_o),
        .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
        .bus_data_i(bus_data_i), .bus_wait_i(bus_wait_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic req_of(input int n);
        return (n == 0) ? (m0_re_i | m0_we_i) : (m1_re_i | m1_we_i);
    endfunction

    function automatic logic lock_of(input int n);
        return (n == 0) ? m0_lock_i : m1_lock_i;
    endfunction

    // Which master the rules put on the bus right now (-1 = nobody).
    function automatic int drv_idx();
        if (rst) return -1;
        if (m_own >= 0) return req_of(m_own) ? m_own : -1;
        if (req_of(0) && req_of(1)) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req_of(0)) return 0;
        if (req_of(1)) return 1;
        return -1;
    endfunction

    // Compare process: every output against the model, once per cycle.
    always @(negedge clk) begin
        int d;
        logic [23:0] ea;
        logic [15:0] ed;
        logic er, ew;
        d  = drv_idx();
        ea = (d == 0) ? m0_addr_i  : (d == 1) ? m1_addr_i  : 24'h0;
        ed = (d == 0) ? m0_wdata_i : (d == 1) ? m1_wdata_i : 16'h0;
        er = (d == 0) ? m0_re_i    : (d == 1) ? m1_re_i    : 1'b0;
        ew = (d == 0) ? m0_we_i    : (d == 1) ? m1_we_i    : 1'b0;
        chk("bus_addr", bus_addr_o, ea);
        chk("bus_re", bus_re_o, er);
        chk("bus_we", bus_we_o, ew);
        chk("bus_data", bus_data_o, ed);
        chk("bus_oe", bus_data_oe_o, ew);
        chk("m0_wait", m0_wait_o, req_of(0) && !(d == 0 && !bus_wait_i));
        chk("m1_wait", m1_wait_o, req_of(1) && !(d == 1 && !bus_wait_i));
        chk("m0_rdata", m0_rdata_o, bus_data_i);
        chk("m1_rdata", m1_rdata_o, bus_data_i);
        chk("grant", grant_o, (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10));
    end

    // Model advance: ownership taken on a stalled access or a locked
    // completion, released on abandon, unlocked completion or LOCK_MAX.
    always @(posedge clk or posedge rst) begin
        int d;
        if (rst) begin
            m_own  <= -1;
            m_last <= 1;
            m_held <= 0;
        end else begin
            d = drv_idx();
            if (d < 0) begin
                m_own  <= -1;
                m_held <= 0;
            end else if (bus_wait_i) begin
                if (m_own < 0) begin
                    m_own  <= d;
                    m_held <= 0;
                end
            end else begin
                m_last <= d;
                if (lock_of(d) && (((m_own < 0) ? 1 : m_held + 1) < TB_LM)) begin
                    m_own  <= d;
                    m_held <= (m_own < 0) ? 1 : m_held + 1;
                end else begin
                    m_own  <= -1;
                    m_held <= 0;
                end
            end
        end
    end

    task automatic clr();
        m0_re_i = 0; m0_we_i = 0; m0_lock_i = 0;
        m1_re_i = 0; m1_we_i = 0; m1_lock_i = 0;
        bus_wait_i = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        nxt();
        rst = 0;
    endtask

    initial begin
        int rel;
        logic [1:0] op;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state, no requests.
        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_re", bus_re_o, 1'b0);
        chk("rst_addr", bus_addr_o, 24'h0);
        nxt();

        // Uncontended single-cycle read by m0.
        m0_re_i = 1; m0_addr_i = 24'h001000;
        @(negedge clk);
        chk("t1_re", bus_re_o, 1'b1);
        chk("t1_addr", bus_addr_o, 24'h001000);
        chk("t1_m0wait", m0_wait_o, 1'b0);
        chk("t1_grant", grant_o, 2'b00);
        nxt(); clr();
        @(negedge clk);
        chk("t1_grant_after", grant_o, 2'b00);
        nxt();

        // Both masters write right after reset.
        do_reset();
        m0_we_i = 1; m0_addr_i = 24'h000010; m0_wdata_i = 16'h1111;
        m1_we_i = 1; m1_addr_i = 24'h000020; m1_wdata_i = 16'h2222;
        @(negedge clk);
        chk("t2_c0_addr", bus_addr_o, 24'h000010);
        chk("t2_c0_data", bus_data_o, 16'h1111);
        chk("t2_c0_m1wait", m1_wait_o, 1'b1);
        nxt();
        @(negedge clk);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        chk("t2_c1_addr", bus_addr_o, 24'h000020);
        chk("t2_c1_data", bus_data_o, 16'h2222);
        chk("t2_c1_m0wait", m0_wait_o, 1'b1);
`else
        chk("t2_c1_addr", bus_addr_o, 24'h000010);
        chk("t2_c1_m1wait", m1_wait_o, 1'b1);
`endif
        nxt(); clr(); nxt();

        // m1 read stretched by 3 wait cycles while m0 requests.
        m1_re_i = 1; m1_addr_i = 24'h000300; bus_wait_i = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin m0_re_i = 1; m0_addr_i = 24'h000400; end
            if (c == 4) bus_wait_i = 0;
            @(negedge clk);
            chk("t3_hold_addr", bus_addr_o, 24'h000300);
            if (c >= 2) chk("t3_m0wait", m0_wait_o, 1'b1);
            nxt();
        end
        @(negedge clk);
        chk("t3_c5_addr", bus_addr_o, 24'h000400);
        chk("t3_c5_m0wait", m0_wait_o, 1'b0);
        chk("t3_c5_m1wait", m1_wait_o, 1'b1);
        nxt(); clr(); nxt();

        // Reset during a stalled m0 write.
        m0_we_i = 1; m0_addr_i = 24'h000500; m0_wdata_i = 16'hABCD; bus_wait_i = 1;
        nxt();
        @(negedge clk);
        chk("t4_we_before", bus_we_o, 1'b1);
        chk("t4_grant_before", grant_o, 2'b01);
        #2 rst = 1;
        #1;
        chk("t4_we_async", bus_we_o, 1'b0);
        chk("t4_grant_async", grant_o, 2'b00);
        chk("t4_m0wait_rst", m0_wait_o, 1'b1);
        nxt();
        rst = 0; clr();
        m0_re_i = 1; m0_addr_i = 24'h000600;
        m1_re_i = 1; m1_addr_i = 24'h000700;
        @(negedge clk);
        chk("t4_tie_addr", bus_addr_o, 24'h000600);
        chk("t4_idle_grant", grant_o, 2'b00);
        nxt();

        // Repeated ties (last winner is m0 here).
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef BUS_ARB_ROUND_ROBIN_EN
            chk("t5_tie_addr", bus_addr_o, (c % 2 == 0) ? 24'h000700 : 24'h000600);
`else
            chk("t5_tie_addr", bus_addr_o, 24'h000600);
            chk("t5_m1wait", m1_wait_o, 1'b1);
`endif
            nxt();
        end
        m0_re_i = 0;
        @(negedge clk);
        chk("t5_m1_after", bus_addr_o, 24'h000700);
        nxt(); clr(); nxt();

        // Locked m0 burst with m1 waiting: released after 16 completions.
        m0_we_i = 1; m0_lock_i = 1; m0_addr_i = 24'h000800;
        rel = 99;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) begin m1_re_i = 1; m1_addr_i = 24'h000900; end
            @(negedge clk);
            if (k >= 2 && grant_o == 2'b00) begin
                rel = k;
                break;
            end
            nxt();
        end
        chk("t6_release_cycle", rel, 17);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        chk("t6_m1_next", bus_addr_o, 24'h000900);
`else
        chk("t6_m0_again", bus_addr_o, 24'h000800);
`endif
        nxt(); clr(); nxt();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            op = 2'($urandom_range(0, 3));
            m0_re_i = (op == 2'd1) || (op == 2'd3); m0_we_i = (op == 2'd2);
            op = 2'($urandom_range(0, 3));
            m1_re_i = (op == 2'd1) || (op == 2'd3); m1_we_i = (op == 2'd2);
            m0_lock_i = ($urandom_range(0, 3) != 0);
            m1_lock_i = ($urandom_range(0, 3) != 0);
            m0_addr_i = 24'($urandom); m1_addr_i = 24'($urandom);
            m0_wdata_i = 16'($urandom); m1_wdata_i = 16'($urandom);
            bus_data_i = 16'($urandom);
            bus_wait_i = ($urandom_range(0, 3) == 0);
            nxt();
        end
        rst = 0; clr();
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
